vend_multi: RTL
===============

# vend_multi

Parametrised vending controller, the next generation of the fixed-price 3-bit vend FSM. It accumulates credit from variable-value coins up to a configurable ceiling and rejects coins that would overflow it. On a purchase request it holds a product strobe until the dispenser acknowledges, then pays back change one unit per cycle. A cancel request refunds the full credit. It sits between the coin acceptor and the product and change dispensers.

## Interface
- VW, 4, coin value width in units
- CW, 8, credit register width
- PRICE, 15, product price in units; must satisfy 1 <= PRICE <= MAX_CREDIT
- MAX_CREDIT, 60, credit ceiling; must be < 2^CW
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- coin_vld  in  1  coin present this cycle
- coin_val  in  VW  coin value in units; sampled only when coin_vld=1
- buy  in  1  purchase request, level-sampled
- cancel  in  1  refund request, level-sampled
- prod_ack  in  1  dispenser has taken the product
- prod  out  1  product strobe, held high until acknowledged
- chg  out  1  change strobe, one cycle per unit returned
- coin_rej  out  1  one-cycle pulse: a coin was returned
- credit  out  CW  current credit in units
- busy  out  1  high when not in IDLE

## Operation
- States: IDLE, VEND, CHANGE. The state register resets to IDLE.
- Outputs decode from registers:
  - prod = (state==VEND)
  - chg = (state==CHANGE)
  - busy = (state!=IDLE)
  - coin_rej and credit are registers.
- Reset values: state IDLE, credit 0, coin_rej 0; hence prod=chg=busy=0.
- Coin acceptance: a coin is "offered" when coin_vld=1 and coin_val!=0. coin_vld=1 with coin_val=0 is ignored silently, with no reject.
- IDLE evaluation order, per cycle:
  1. cancel=1 and credit>0: go to CHANGE, credit unchanged. Any offered coin is rejected.
  2. cancel=1 and credit=0: stay in IDLE. Any offered coin is rejected.
  3. buy=1 and credit>=PRICE: go to VEND, credit <= credit-PRICE. Any offered coin is rejected.
  4. Otherwise (including buy=1 with credit<PRICE, which is ignored): if an offered coin satisfies credit+coin_val <= MAX_CREDIT, then credit <= credit+coin_val. Else reject it.
- The coin check compares credit+coin_val against MAX_CREDIT at CW+1 bits, so no wrap-around is possible.
- VEND: hold until prod_ack=1 is sampled. Then go to CHANGE if credit>0, else to IDLE. Offered coins are rejected. buy and cancel are ignored.
- CHANGE: credit decrements by 1 each cycle. When credit==1 is decremented to 0, the state returns to IDLE. Offered coins are rejected. buy and cancel are ignored.
- Reject: coin_rej <= 1 for the cycle after each rejected coin, otherwise 0.
- rst=1 in any state, including mid-VEND or mid-CHANGE: state, credit and coin_rej clear at the next edge. Undelivered change is forfeited; this is accepted behaviour.

## Timing
- A coin accepted at edge k is visible on credit after edge k, one cycle latency.
- buy sampled at edge k: prod=1 and credit reduced, both from edge k onward.
- prod_ack is only meaningful while prod=1. If ack is high at edge k, prod falls after edge k, giving a minimum prod width of 1 cycle.
- CHANGE lasts exactly N cycles for entry credit N. chg is high for N consecutive cycles and credit counts N..1 during them.
- coin_rej pulses 1 cycle after the offending coin_vld edge. Back-to-back rejects give back-to-back pulses.
- The block is ready for a new coin on the cycle after it returns to IDLE.

## Test plan
- Reset: assert rst for 2 cycles mid-traffic -> prod=chg=coin_rej=busy=0 and credit=0 on the cycle after release.
- Exact payment: coins 5 then 10, then buy -> credit 15 then 0, prod=1. prod_ack 3 cycles later -> prod held for 3 cycles, then IDLE with no chg pulses.
- Change: coins 10 and 10 (credit 20), then buy -> credit 5, prod=1. After ack -> exactly 5 chg cycles with credit 5,4,3,2,1, then credit=0 and busy=0.
- Insufficient/overflow: credit 10 with buy -> ignored, stays IDLE. Credit 55 with coin 10 -> coin_rej for 1 cycle, credit stays 55. Coin 5 -> credit 60.
- Cancel: credit 7 with cancel and coin 4 in the same cycle -> coin_rej=1, then 7 chg pulses, credit to 0. Cancel at credit 0 -> no state change.
- Busy rejects and reset mid-operation: a coin during VEND -> coin_rej=1 and credit unchanged. rst during CHANGE at credit 3 -> next cycle IDLE, credit 0, chg 0.

Source files
------------

// File: rtl/vend_multi.sv
// Parametrised vending controller: accumulates coin credit up to a ceiling,
// strobes a product until acknowledged, then pays change one unit per cycle.
module vend_multi #(
    parameter int VW         = 4,
    parameter int CW         = 8,
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_vld,
    input  logic [VW-1:0] coin_val,
    input  logic          buy,
    input  logic          cancel,
    input  logic          prod_ack,
    output logic          prod,
    output logic          chg,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);

    state_t        state, state_nxt;
    logic [CW-1:0] credit_nxt;
    logic          rej_nxt;
    logic          offered;
    logic [CW:0]   coin_ext, sum;

    // One extra bit on the sum so an overflowing coin can never wrap under the ceiling.
    assign offered  = coin_vld && (coin_val != '0);
    assign coin_ext = (CW+1)'(coin_val);
    assign sum      = {1'b0, credit} + coin_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            coin_rej <= rej_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        rej_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (cancel) begin
                    rej_nxt = offered;
                    if (credit != '0) state_nxt = CHANGE;
                end else if (buy && credit >= PRICE_C) begin
                    state_nxt  = VEND;
                    credit_nxt = credit - PRICE_C;
                    rej_nxt    = offered;
                end else if (offered) begin
                    if (sum <= MAX_C) credit_nxt = sum[CW-1:0];
                    else              rej_nxt    = 1'b1;
                end
            end
            VEND: begin
                rej_nxt = offered;
                if (prod_ack) state_nxt = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_nxt = offered;
                // Last unit (or a defensive zero) drops straight back to IDLE.
                if (credit <= CW'(1)) begin
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    credit_nxt = credit - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prod = (state == VEND);
    assign chg  = (state == CHANGE);
    assign busy = (state != IDLE);
endmodule
